imem_ctrl: RTL
==============

# imem_ctrl

Load, clear and run-control sequencer for the byte-addressed instruction memory. After reset it zeroes every byte, accepts a program as a byte stream through a valid/ready handshake, then releases the pipeline. It stops the pipeline on the HALT opcode or on an illegal fetch address, and allows a reload or restart without a global reset. It sits between the host/testbench loader, the memory write port and the core's stall/reset inputs.

## Interface
- MEM_BYTES, 128, instruction memory size in bytes (power of two, ≥8)
- AW, 7, memory byte-address width, log2(MEM_BYTES)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ld_start  in  1  request a (re)load session
- ld_valid  in  1  loader byte valid
- ld_data  in  8  loader byte, written little-endian (byte 0 = instrn[7:0])
- ld_last  in  1  marks final byte of program, qualified by ld_valid
- ld_ready  out  1  controller accepts a byte this cycle
- mem_we  out  1  memory byte write enable
- mem_waddr  out  AW  memory byte write address
- mem_wdata  out  8  memory byte write data
- fetch_pc  in  32  current pipeline fetch address
- halt_det  in  1  decode stage saw opcode 7'b1111111
- restart  in  1  rerun the loaded program from PC 0
- core_rst  out  1  holds pipeline (PC, pipeline registers) in reset
- core_stall  out  1  freezes pipeline
- state  out  3  current state encoding
- ld_ovf  out  1  sticky: load filled memory without ld_last
- fault  out  1  sticky: illegal fetch address seen in RUN
- run_cycles  out  32  cycles spent in RUN since last load/restart, saturating

## Operation
- States and encodings: CLEAR=0, IDLE=1, LOAD=2, RUN=3, HALTED=4, FAULT=5.
- Reset:
  - Enters CLEAR with clr_ptr=0, load_pend=0, ld_ovf=0, fault=0, run_cycles=0.
  - Output values while rst is high: core_rst=1, core_stall=1, ld_ready=0, mem_we=0, state=0.
- CLEAR:
  - Per cycle: mem_we=1, mem_waddr=clr_ptr, mem_wdata=0; clr_ptr increments.
  - After writing MEM_BYTES-1, goes to LOAD if load_pend, otherwise IDLE. load_pend is cleared on exit.
  - ld_start is ignored in CLEAR, except that it sets load_pend.
- IDLE: ld_start goes to LOAD with ld_ptr=0.
- LOAD:
  - ld_ready=1.
  - On ld_valid&ld_ready: mem_we=1, mem_waddr=ld_ptr, mem_wdata=ld_data, and ld_ptr increments.
  - Exits to RUN when the accepted byte has ld_last=1, or when that byte was at address MEM_BYTES-1.
  - In the second case with ld_last=0, ld_ovf is set.
  - Entering LOAD clears ld_ovf, fault and run_cycles.
- RUN:
  - core_rst=0, core_stall=0; run_cycles increments, saturating at 32'hFFFF_FFFF.
  - Priority order when several conditions hold in the same cycle:
    - ld_start goes to CLEAR with load_pend=1.
    - Otherwise halt_det goes to HALTED (older instruction wins over fetch fault).
    - Otherwise an illegal fetch_pc goes to FAULT and sets fault.
  - Illegal fetch_pc means fetch_pc[1:0]≠0 or fetch_pc > MEM_BYTES-4 (unsigned 32-bit compare).
- HALTED and FAULT:
  - core_stall=1, core_rst=0 (architectural state stays observable).
  - ld_start goes to CLEAR with load_pend=1; it has priority over restart.
  - restart goes to RUN, with core_rst=1 for the first RUN cycle, run_cycles=0 and fault cleared.
- In CLEAR, IDLE and LOAD: core_rst=1 and core_stall=1.
- mem_we is never asserted in RUN, HALTED or FAULT.

## Timing
- state, core_rst, core_stall, ld_ready, ld_ovf, fault and run_cycles are registered (Moore).
- mem_we, mem_waddr and mem_wdata are combinational from state, pointers and ld_valid/ld_data. The memory captures them on the same edge that advances the pointer.
- Handshake:
  - A byte transfers on a clk edge with ld_valid&ld_ready.
  - ld_data/ld_last must be held by the loader until accepted.
  - ld_ready deasserts the cycle after the final accepted byte.
- Latencies:
  - Reset to IDLE: exactly MEM_BYTES cycles.
  - ld_start in IDLE: ld_ready=1 on the next cycle.
  - Last byte accepted at edge N: core_rst=0 from edge N.
  - halt_det/fault sampled at edge N: core_stall=1 from edge N.
- Reload from RUN, HALTED or FAULT: MEM_BYTES CLEAR cycles, then LOAD directly, with no IDLE cycle.
- rst asserted mid-CLEAR, mid-LOAD or mid-RUN aborts immediately and restarts CLEAR at address 0. A partially loaded program is erased.

## Test plan
- Reset 1 cycle, then no stimulus:
  - Required: exactly 128 writes of 0x00 to addresses 0..127, then state=1, core_rst=1, ld_ready=0.
- Load 48 bytes (addresses 0..47) with ld_last on byte 47 and random ld_valid gaps:
  - Required: each byte written once at its address.
  - Required: state=3 and core_rst=0 on the edge accepting byte 47; ld_ovf=0.
- Load 128 bytes without ld_last:
  - Required: after the write to 127, state=3 and ld_ovf=1.
  - Required: the 129th presented byte is not accepted (ld_ready=0).
- In RUN, assert halt_det and fetch_pc=0x2 in the same cycle:
  - Required: state=4 (not 5), fault=0, core_stall=1, run_cycles frozen.
  - Then restart: state=3, core_rst=1 for 1 cycle, run_cycles restarts from 0.
- In RUN, fetch_pc=0x7C, then 0x80:
  - Required: 0x7C is legal; 0x80 gives state=5 and fault=1.
  - Then ld_start: 128 CLEAR writes, state=2, fault cleared.
- Assert rst on the 10th byte of a load:
  - Required: CLEAR restarts at address 0, and all written bytes read back 0x00.

Source files
------------

// File: rtl/imem_ctrl.sv
// imem_ctrl: clear/load/run sequencer for the byte-addressed instruction memory
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   ld_start                   request a (re)load session
//   ld_valid/ld_data/ld_last   loader byte stream (valid/ready), ld_last marks final byte
//   ld_ready                   byte accepted on this cycle's edge when ld_valid is high
//   mem_we/mem_waddr/mem_wdata memory byte write port (combinational)
//   fetch_pc                   pipeline fetch address, checked for legality in RUN
//   halt_det                   decode stage saw the HALT opcode
//   restart                    rerun the loaded program from PC 0
//   core_rst/core_stall        pipeline reset and freeze
//   state                      CLEAR=0 IDLE=1 LOAD=2 RUN=3 HALTED=4 FAULT=5
//   ld_ovf/fault               sticky load-overflow and illegal-fetch flags
//   run_cycles                 saturating count of RUN cycles since last load/restart
module imem_ctrl #(
  parameter int MEM_BYTES = 128,
  parameter int AW        = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [7:0]    mem_wdata,
  input  logic [31:0]   fetch_pc,
  input  logic          halt_det,
  input  logic          restart,
  output logic          core_rst,
  output logic          core_stall,
  output logic [2:0]    state,
  output logic          ld_ovf,
  output logic          fault,
  output logic [31:0]   run_cycles
);
  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_BYTES - 1);
  localparam logic [31:0]   PC_MAX    = 32'(MEM_BYTES - 4);

  logic [2:0]    r_state;
  logic [2:0]    w_nxt;
  logic [AW-1:0] r_clr_ptr;
  logic [AW-1:0] r_ld_ptr;
  logic          r_load_pend;
  logic          r_core_rst;
  logic          r_core_stall;
  logic          r_ld_ready;
  logic          r_ld_ovf;
  logic          r_fault;
  logic [31:0]   r_run_cycles;

  logic          w_acc;
  logic          w_bad_pc;
  logic          w_stopped;
  logic          w_restart;
  logic          w_enter_load;
  logic          w_ovf_hit;
  logic [AW-1:0] w_clr_ptr_n;
  logic [AW-1:0] w_ld_ptr_n;
  logic          w_load_pend_n;
  logic          w_core_rst_n;
  logic          w_core_stall_n;
  logic          w_ld_ready_n;
  logic          w_ld_ovf_n;
  logic          w_fault_n;
  logic [31:0]   w_run_cycles_n;

  assign w_acc     = (r_state == S_LOAD) && ld_valid;
  // Instructions are word aligned and the whole 4-byte word must lie inside memory
  assign w_bad_pc  = (fetch_pc[1:0] != 2'b00) || (fetch_pc > PC_MAX);
  assign w_stopped = (r_state == S_HALTED) || (r_state == S_FAULT);
  // A reload request outranks restart in HALTED/FAULT
  assign w_restart = w_stopped && !ld_start && restart;
  assign w_ovf_hit = w_acc && !ld_last && (r_ld_ptr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_CLEAR;
      r_clr_ptr    <= '0;
      r_ld_ptr     <= '0;
      r_load_pend  <= 1'b0;
      r_core_rst   <= 1'b1;
      r_core_stall <= 1'b1;
      r_ld_ready   <= 1'b0;
      r_ld_ovf     <= 1'b0;
      r_fault      <= 1'b0;
      r_run_cycles <= '0;
    end else begin
      r_state      <= w_nxt;
      r_clr_ptr    <= w_clr_ptr_n;
      r_ld_ptr     <= w_ld_ptr_n;
      r_load_pend  <= w_load_pend_n;
      r_core_rst   <= w_core_rst_n;
      r_core_stall <= w_core_stall_n;
      r_ld_ready   <= w_ld_ready_n;
      r_ld_ovf     <= w_ld_ovf_n;
      r_fault      <= w_fault_n;
      r_run_cycles <= w_run_cycles_n;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_CLEAR:  w_nxt = (r_clr_ptr != LAST_ADDR) ? S_CLEAR :
                        (r_load_pend || ld_start) ? S_LOAD : S_IDLE;
      S_IDLE:   w_nxt = ld_start ? S_LOAD : S_IDLE;
      S_LOAD:   w_nxt = (w_acc && (ld_last || r_ld_ptr == LAST_ADDR)) ? S_RUN : S_LOAD;
      // HALT is from an older instruction than the fetch, so it beats a fetch fault
      S_RUN:    w_nxt = ld_start ? S_CLEAR : halt_det ? S_HALTED : w_bad_pc ? S_FAULT : S_RUN;
      S_HALTED,
      S_FAULT:  w_nxt = ld_start ? S_CLEAR : restart ? S_RUN : r_state;
      default:  w_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    w_enter_load   = (w_nxt == S_LOAD) && (r_state != S_LOAD);
    w_clr_ptr_n    = (r_state == S_CLEAR) ? r_clr_ptr + 1'b1 : '0;
    w_ld_ptr_n     = w_enter_load ? '0 : w_acc ? r_ld_ptr + 1'b1 : r_ld_ptr;
    // load_pend remembers a reload request across the CLEAR sweep and drops on exit
    w_load_pend_n  = (w_nxt == S_CLEAR) && ((r_state != S_CLEAR) || r_load_pend || ld_start);
    // The first RUN cycle after restart keeps the core in reset so PC restarts at 0
    w_core_rst_n   = (w_nxt == S_CLEAR) || (w_nxt == S_IDLE) || (w_nxt == S_LOAD) || w_restart;
    w_core_stall_n = (w_nxt != S_RUN);
    w_ld_ready_n   = (w_nxt == S_LOAD);
    w_ld_ovf_n     = w_enter_load ? 1'b0 : w_ovf_hit ? 1'b1 : r_ld_ovf;
    w_fault_n      = (w_enter_load || w_restart) ? 1'b0 :
                     (r_state == S_RUN && w_nxt == S_FAULT) ? 1'b1 : r_fault;
    w_run_cycles_n = (w_enter_load || w_restart) ? '0 :
                     (r_state == S_RUN && !(&r_run_cycles)) ? r_run_cycles + 32'd1 : r_run_cycles;
  end

  // Write port is combinational so the memory captures on the same edge the pointer advances
  assign mem_we     = !rst && ((r_state == S_CLEAR) || w_acc);
  assign mem_waddr  = (r_state == S_CLEAR) ? r_clr_ptr : r_ld_ptr;
  assign mem_wdata  = (r_state == S_CLEAR) ? 8'h00 : ld_data;

  assign state      = r_state;
  assign ld_ready   = r_ld_ready;
  assign core_rst   = r_core_rst;
  assign core_stall = r_core_stall;
  assign ld_ovf     = r_ld_ovf;
  assign fault      = r_fault;
  assign run_cycles = r_run_cycles;
endmodule
